// File: rtl/sha256_stream_ctrl_if.sv
// Message-stream and sha256-core signals of the stream controller.
// slave = controller side, master = bus/core side.
interface sha256_stream_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         busy;
  logic         digest_valid;
  logic [255:0] digest;
  logic         core_load_hash;
  logic [255:0] core_hash_in;
  logic         core_gen_hash;
  logic [511:0] core_msg;
  logic         core_block_ready;
  logic [255:0] core_hash_out;

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, core_block_ready, core_hash_out,
    output in_ready, busy, digest_valid, digest, core_load_hash, core_hash_in,
           core_gen_hash, core_msg
  );

  modport master (
    output in_valid, in_data, in_last, in_bytes, core_block_ready, core_hash_out,
    input  in_ready, busy, digest_valid, digest, core_load_hash, core_hash_in,
           core_gen_hash, core_msg
  );
endinterface

// File: rtl/sha256_stream_ctrl.sv
// Packs 32-bit message words into padded SHA-256 blocks and sequences one core; one word
// per cycle in FILL, in_ready low in IDLE/LOAD_IV/PAD/START/WAIT; digest pulses one cycle after the last block_ready.
module sha256_stream_ctrl #(
  parameter logic [255:0] IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19,
  parameter int           LEN_W = 61
) (
  input  logic             clk,
  input  logic             rst_n,
  sha256_stream_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD_IV, FILL, PAD, START, WAIT} state_e;

  state_e             state_q, state_d;
  logic [3:0]         widx_q, widx_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               pad80_q, pad80_d;
  logic               fin_q, fin_d;
  logic               ended_q, ended_d;
  logic [511:0]       msg_q, msg_d;
  logic [255:0]       digest_q, digest_d;
  logic               dvld_q, dvld_d;

  logic [2:0]         nbytes;
  logic [31:0]        last_word;
  logic [8:0]         slot_lsb;
  logic [63:0]        bit_len;

  // Last word: keep the valid leading bytes, append the 0x80 marker right after them.
  always_comb begin
    nbytes    = (bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;
    last_word = '0;
    for (int b = 0; b < 4; b++) begin
      if (b < int'(nbytes)) begin
        last_word[31-8*b -: 8] = bus.in_data[31-8*b -: 8];
      end else if (b == int'(nbytes)) begin
        last_word[31-8*b -: 8] = 8'h80;
      end
    end
    slot_lsb = {~widx_q, 5'b00000};
    bit_len  = 64'({cnt_q, 3'b000});
  end

  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    cnt_d    = cnt_q;
    pad80_d  = pad80_q;
    fin_d    = fin_q;
    ended_d  = ended_q;
    msg_d    = msg_q;
    digest_d = digest_q;
    dvld_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) state_d = LOAD_IV;
      end
      LOAD_IV: begin
        widx_d  = '0;
        cnt_d   = '0;
        pad80_d = 1'b0;
        fin_d   = 1'b0;
        ended_d = 1'b0;
        state_d = FILL;
      end
      FILL: begin
        if (bus.in_valid) begin
          widx_d = widx_q + 4'd1;
          if (bus.in_last) begin
            msg_d[slot_lsb +: 32] = last_word;
            cnt_d   = cnt_q + LEN_W'(nbytes);
            pad80_d = (nbytes != 3'd4);
            ended_d = 1'b1;
            state_d = (widx_q == 4'd15) ? START : PAD;
          end else begin
            msg_d[slot_lsb +: 32] = bus.in_data;
            cnt_d = cnt_q + LEN_W'(4);
            if (widx_q == 4'd15) state_d = START;
          end
        end
      end
      PAD: begin
        // Length words only fit once the 0x80 marker is placed and slots 14/15 are free.
        if (widx_q == 4'd14 && pad80_q) begin
          msg_d[63:32] = bit_len[63:32];
          msg_d[31:0]  = bit_len[31:0];
          fin_d        = 1'b1;
          state_d      = START;
        end else begin
          msg_d[slot_lsb +: 32] = pad80_q ? 32'h0 : 32'h80000000;
          pad80_d = 1'b1;
          widx_d  = widx_q + 4'd1;
          if (widx_q == 4'd15) state_d = START;
        end
      end
      START: begin
        widx_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.core_block_ready) begin
          if (fin_q) begin
            digest_d = bus.core_hash_out;
            dvld_d   = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = ended_q ? PAD : FILL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      widx_q   <= '0;
      cnt_q    <= '0;
      pad80_q  <= 1'b0;
      fin_q    <= 1'b0;
      ended_q  <= 1'b0;
      msg_q    <= '0;
      digest_q <= '0;
      dvld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      cnt_q    <= cnt_d;
      pad80_q  <= pad80_d;
      fin_q    <= fin_d;
      ended_q  <= ended_d;
      msg_q    <= msg_d;
      digest_q <= digest_d;
      dvld_q   <= dvld_d;
    end
  end

  assign bus.in_ready       = (state_q == FILL);
  assign bus.busy           = (state_q != IDLE);
  assign bus.core_load_hash = (state_q == LOAD_IV);
  assign bus.core_gen_hash  = (state_q == START);
  assign bus.core_hash_in   = IV;
  assign bus.core_msg       = msg_q;
  assign bus.digest         = digest_q;
  assign bus.digest_valid   = dvld_q;

endmodule

// File: tb/tb_sha256_stream_ctrl.sv
// Bench for sha256_stream_ctrl: table of messages fed through a behavioural SHA-256 core
// with random latency, plus a reset-abort sequence.
module tb_sha256_stream_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sha256_stream_ctrl_if bus();
  sha256_stream_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef struct {
    int           kind;       // 0: "abcdbcde..." string, 1: "abc..", 2: byte ramp
    int           len;
    bit           empty_tail; // end a multiple-of-4 message with an in_bytes=0 word
    bit           over;       // drive in_bytes=7 on a full last word
    int           exp_blocks;
    bit           known;
    logic [255:0] exp_dig;
  } vec_t;

  vec_t         vt [11];
  int           checks = 0;
  int           errors = 0;
  int           gen_cnt = 0;
  int           dv_cnt = 0;
  int           force_lat = 0;
  int           lat;
  bit           pend;
  logic [511:0] cap;
  logic [255:0] hstate;
  logic [255:0] dig_cap;
  logic [511:0] blk_q [$];
  logic [511:0] exp_q [$];
  logic [447:0] longs;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_cmp(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    {a, b, c, d, e, f, g, h} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  function automatic logic [7:0] msgb(input int kind, input int i);
    if (kind == 0) return longs[447-8*i -: 8];
    if (kind == 1) return 8'(32'h61 + i);
    return 8'(i * 7 + 3);
  endfunction

  // Reference padding built byte-wise from the message definition.
  task automatic build_exp(input int kind, input int len);
    logic [7:0]  bq [$];
    logic [63:0] bl;
    logic [511:0] blk;
    exp_q.delete();
    for (int i = 0; i < len; i++) bq.push_back(msgb(kind, i));
    bq.push_back(8'h80);
    while (bq.size() % 64 != 56) bq.push_back(8'h00);
    bl = 64'(len) << 3;
    for (int i = 7; i >= 0; i--) bq.push_back(bl[8*i +: 8]);
    for (int bi = 0; bi < bq.size() / 64; bi++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = bq[64*bi + j];
      exp_q.push_back(blk);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input bit last, input logic [2:0] nb);
    int gap;
    int t;
    gap = $urandom_range(0, 3);
    repeat (gap) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_bytes = nb;
    t = 0;
    while (!bus.in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, expected 1", t);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = $urandom;
  endtask

  function automatic logic [31:0] full_word(input int kind, input int wi);
    return {msgb(kind, 4*wi), msgb(kind, 4*wi+1), msgb(kind, 4*wi+2), msgb(kind, 4*wi+3)};
  endfunction

  task automatic send_msg(input int kind, input int len, input bit empty_tail, input bit over);
    int nw;
    int rem;
    logic [31:0] w;
    logic [7:0]  g;
    nw  = len / 4;
    rem = len % 4;
    g   = (kind == 1) ? 8'h00 : 8'hFF;
    if (rem != 0) begin
      for (int i = 0; i < nw; i++) send_word(full_word(kind, i), 1'b0, 3'($urandom_range(0, 7)));
      for (int b = 0; b < 4; b++) w[31-8*b -: 8] = (b < rem) ? msgb(kind, 4*nw + b) : g;
      send_word(w, 1'b1, 3'(rem));
    end else if (len == 0 || empty_tail) begin
      for (int i = 0; i < nw; i++) send_word(full_word(kind, i), 1'b0, 3'($urandom_range(0, 7)));
      send_word(32'hDEADBEEF, 1'b1, 3'd0);
    end else begin
      for (int i = 0; i < nw - 1; i++) send_word(full_word(kind, i), 1'b0, 3'($urandom_range(0, 7)));
      send_word(full_word(kind, nw - 1), 1'b1, over ? 3'd7 : 3'd4);
    end
  endtask

  task automatic run_vec(input int idx);
    int t;
    logic [255:0] expd;
    blk_q.delete();
    gen_cnt = 0;
    dv_cnt  = 0;
    build_exp(vt[idx].kind, vt[idx].len);
    send_msg(vt[idx].kind, vt[idx].len, vt[idx].empty_tail, vt[idx].over);
    chk($sformatf("v%0d_busy", idx), bus.busy, 1);
    t = 0;
    while (dv_cnt == 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk($sformatf("v%0d_digest_valid_count", idx), dv_cnt, 1);
    chk($sformatf("v%0d_gen_hash_count", idx), gen_cnt, vt[idx].exp_blocks);
    for (int b = 0; b < exp_q.size(); b++)
      chk($sformatf("v%0d_block%0d", idx, b), (b < blk_q.size()) ? blk_q[b] : 512'h0, exp_q[b]);
    expd = IV;
    for (int b = 0; b < exp_q.size(); b++) expd = sha_cmp(expd, exp_q[b]);
    if (vt[idx].known) expd = vt[idx].exp_dig;
    chk($sformatf("v%0d_digest_at_valid", idx), dig_cap, expd);
    chk($sformatf("v%0d_digest_held", idx), bus.digest, expd);
    chk($sformatf("v%0d_idle", idx), bus.busy, 0);
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_in_ready"}, bus.in_ready, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_digest_valid"}, bus.digest_valid, 0);
    chk({nm, "_digest"}, bus.digest, 0);
    chk({nm, "_load_hash"}, bus.core_load_hash, 0);
    chk({nm, "_gen_hash"}, bus.core_gen_hash, 0);
    chk({nm, "_core_msg"}, bus.core_msg, 0);
  endtask

  // Behavioural core: real SHA-256 compression, 1..70 cycle latency, stray block_ready pulses when idle.
  initial begin
    bus.core_block_ready = 1'b0;
    bus.core_hash_out    = '0;
    pend   = 1'b0;
    lat    = 0;
    hstate = IV;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
        bus.core_block_ready = 1'b0;
      end else begin
        bus.core_block_ready = 1'b0;
        if (bus.digest_valid) begin
          dv_cnt++;
          dig_cap = bus.digest;
        end
        if (pend) begin
          chk("wait_msg_stable", bus.core_msg, cap);
          chk("wait_in_ready", bus.in_ready, 0);
          lat--;
          if (lat <= 0) begin
            hstate = sha_cmp(hstate, cap);
            bus.core_hash_out    = hstate;
            bus.core_block_ready = 1'b1;
            pend = 1'b0;
          end
        end else if (bus.core_gen_hash) begin
          cap = bus.core_msg;
          blk_q.push_back(cap);
          gen_cnt++;
          lat  = (force_lat > 0) ? force_lat : $urandom_range(1, 70);
          pend = 1'b1;
        end else if (bus.core_load_hash) begin
          hstate = bus.core_hash_in;
        end else if ($urandom_range(0, 7) == 0) begin
          bus.core_hash_out    = {8{$urandom}};
          bus.core_block_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    longs = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    vt[0]  = '{1,   0, 1'b0, 1'b0, 1, 1'b1, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855};
    vt[1]  = '{1,   3, 1'b0, 1'b0, 1, 1'b1, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad};
    vt[2]  = '{0,  56, 1'b0, 1'b0, 2, 1'b1, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1};
    vt[3]  = '{2,  55, 1'b0, 1'b0, 1, 1'b0, 256'h0};
    vt[4]  = '{2,  64, 1'b0, 1'b0, 2, 1'b0, 256'h0};
    vt[5]  = '{2,  64, 1'b1, 1'b0, 2, 1'b0, 256'h0};
    vt[6]  = '{2,  60, 1'b0, 1'b0, 2, 1'b0, 256'h0};
    vt[7]  = '{2,  63, 1'b0, 1'b0, 2, 1'b0, 256'h0};
    vt[8]  = '{2, 119, 1'b0, 1'b0, 2, 1'b0, 256'h0};
    vt[9]  = '{2, 120, 1'b0, 1'b0, 3, 1'b0, 256'h0};
    vt[10] = '{2,   8, 1'b0, 1'b1, 1, 1'b0, 256'h0};

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.in_bytes = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("hash_in_iv", bus.core_hash_in, IV);

    for (int i = 0; i < 11; i++) run_vec(i);

    // Abort a two-block message while the first block is in flight.
    blk_q.delete();
    gen_cnt   = 0;
    dv_cnt    = 0;
    force_lat = 60;
    send_msg(2, 64, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("abort_in_wait", pend, 1);
    chk("abort_in_ready", bus.in_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("abort_reset");
    rst_n     = 1'b1;
    force_lat = 0;
    repeat (100) @(negedge clk);
    chk("abort_no_digest", dv_cnt, 0);
    chk("abort_gen_count", gen_cnt, 1);
    run_vec(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha256_stream_ctrl.md
Name: sha256_stream_ctrl

Overview:
Sequencer for the sha256 block core. It accepts a message as a stream of 32-bit big-endian words and packs the words into 512-bit blocks. It applies standard SHA-256 padding (0x80, zero fill, 64-bit bit-length), loads the IV, pulses gen_hash once per block and waits for block_ready. After the final block it returns the 256-bit digest. It sits between the accelerator register/bus interface and one sha256 instance.

Parameters:
IV, 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19, initial hash value driven on core_hash_in at message start.
LEN_W, 61, width of the message byte counter; bit length = {cnt,3'b000} zero-extended to 64 bits.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word valid
in_ready  output  1  controller accepts word this cycle (valid&ready = transfer)
in_data  input  32  message word, first byte in [31:24]
in_last  input  1  last word of message
in_bytes  input  3  valid bytes in a last word, 0..4 (0 = empty word, data ignored); ignored when in_last=0 (word counts 4)
busy  output  1  message in progress (state != IDLE)
digest_valid  output  1  one-cycle pulse, digest valid
digest  output  256  final hash, held until next digest_valid
core_load_hash  output  1  one-cycle pulse, load core_hash_in into core chaining state
core_hash_in  output  256  constant IV
core_gen_hash  output  1  one-cycle pulse, start compression of core_msg
core_msg  output  512  block buffer; word i at [511-32i -: 32]
core_block_ready  input  1  core pulse: compression done, core_hash_out valid
core_hash_out  input  256  core chaining state

Behaviour:
- Reset values: state=IDLE, in_ready=0, busy=0, digest_valid=0, digest=0, core_load_hash=0, core_gen_hash=0, core_msg=0, word index widx=0, byte count=0, flags pad80=0 and final=0. Reset mid-operation aborts immediately. No partial digest is output.
- IDLE: in_ready=0. When in_valid=1, go to LOAD_IV. The word is not consumed.
- LOAD_IV (1 cycle): core_load_hash=1, clear counters, go to FILL.
- FILL: in_ready=1.
  - Non-last transfer: write the word to slot widx, widx+=1, count+=4. If widx was 15, go to START with final=0.
  - Last transfer with n=in_bytes: keep the top n bytes and zero the rest. If n<4, put 0x80 at byte n. Write the word to slot widx, widx+=1, count+=n.
  - After a last transfer: pad80=(n<4). If widx was 15, go to START (final=0, continue in PAD). Otherwise go to PAD.
  - in_bytes>4 with in_last is illegal. Treat it as 4.
- PAD: in_ready=0. Each cycle:
  - If widx==14 and pad80=1: write the bit-length high word to slot 14, the low word to slot 15, set final=1, go to START.
  - Otherwise write (pad80 ? 0 : 32'h80000000) to slot widx, set pad80=1, widx+=1. If widx was 15, go to START with final=0 (a length block follows).
- START (1 cycle): core_gen_hash=1, widx<=0, go to WAIT.
- WAIT: core_msg is held stable. On core_block_ready:
  - final=1: digest<=core_hash_out, digest_valid=1 next cycle, go to IDLE.
  - Otherwise, if the message end has not been seen, go to FILL; if it has, go to PAD.
- core_block_ready outside WAIT is ignored. No new message is accepted until digest_valid has been emitted.
- Block count: ceil((bytes+9)/64). Lengths 55 and 56 bytes are the one/two-block boundary. 64k+56..64k+63 bytes add an extra length-only block. A pad-only block (0x80 at word 0) occurs for exact multiples of 64.
- Byte counter wraps modulo 2^LEN_W. There is no error flag.

Test Plan:
- Empty message: single word, in_last=1, in_bytes=0 -> 1 gen_hash; digest=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- "abc": 32'h61626300, in_last=1, in_bytes=3 -> core_msg word0=32'h61626380, word15=32'h00000018; digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- 56-byte "abcdbcdecdefdefg...nopq" (14 words) -> 2 gen_hash pulses, second block all zero except word15=32'h000001c0; digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- 55-byte and 64-byte messages -> 1 and 2 blocks respectively; second block of 64-byte case has word0=32'h80000000, word15=32'h00000200; digests match software model.
- Random in_valid gaps and a core model with 1..70 cycle block_ready latency -> in_ready=0 throughout WAIT and PAD, core_msg stable during WAIT, digests unchanged.
- rst_n low during WAIT of a 2-block message, then "abc" -> no digest_valid for the aborted message; "abc" digest correct.
